flags_stack_reg: RTL and testbench

- Parametrised successor to the CPU flags register: WIDTH flag bits, loaded on clk posedge under an active-low load strobe.
- Adds a per-bit load mask and asynchronous active-low reset.
- Adds a DEPTH-entry save/restore stack so flags survive interrupt/trap entry and return.
- Sits between the ALU flag outputs and the control unit / conditional-jump logic.

---
 rtl/flags_stack_reg_if.sv | 28 ++
 rtl/flags_stack_reg.sv | 101 ++++++++++
 tb/tb_flags_stack_reg.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/flags_stack_reg_if.sv
// Flag register bus: ALU-side load inputs, save/restore strobes,
// and the registered flags/stack status seen by the control unit.
interface flags_stack_reg_if #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] mask;
    logic             load_bar;
    logic             push_bar;
    logic             pop_bar;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             err;

    modport master (
        output in, mask, load_bar, push_bar, pop_bar,
        input  out, count, empty, full, err
    );

    modport slave (
        input  in, mask, load_bar, push_bar, pop_bar,
        output out, count, empty, full, err
    );
endinterface

// File: rtl/flags_stack_reg.sv
// CPU flags register with per-bit load mask and a DEPTH-entry
// LIFO save/restore stack for trap entry/return.
module flags_stack_reg #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset_bar,
    flags_stack_reg_if.slave bus
);
    logic [WIDTH-1:0] flags_q;
    logic [WIDTH-1:0] flags_d;
    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] loaded;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             err_q;
    logic             err_d;
    logic             ld;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign ld    = ~bus.load_bar;
    assign push  = ~bus.push_bar;
    assign pop   = ~bus.pop_bar;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

    assign loaded = (flags_q & ~bus.mask) | (bus.in & bus.mask);

    // Conflicting or impossible stack ops leave the stack untouched.
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt_q == CW'(i + 1)) top = stk_q[i];
        end
    end

    always_comb begin
        flags_d = flags_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (push && pop) begin
            err_d = 1'b1;
        end else if (pop) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                flags_d = top;
                cnt_d   = cnt_q - CW'(1);
            end
        end else begin
            // Push saves the pre-load flags; the load still applies.
            if (push) begin
                if (full) err_d = 1'b1;
                else      cnt_d = cnt_q + CW'(1);
            end
            if (ld) flags_d = loaded;
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            flags_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && cnt_q == CW'(i))
                    stk_q[i] <= flags_q;
                else if (do_pop && cnt_q == CW'(i + 1))
                    stk_q[i] <= '0;
            end
        end
    end

    assign bus.out   = flags_q;
    assign bus.count = cnt_q;
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_flags_stack_reg.sv
// Bench for flags_stack_reg: queue-based reference model compared
// every cycle, plus directed literal checks of the test scenarios.
module tb_flags_stack_reg;
    logic clk = 1'b0;
    logic reset_bar = 1'b0;
    logic started = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    flags_stack_reg_if #(.WIDTH(3), .DEPTH(4)) bus ();

    flags_stack_reg #(.WIDTH(3), .DEPTH(4)) dut (
        .clk       (clk),
        .reset_bar (reset_bar),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [2:0] q[$];
    logic [2:0] mo = '0;
    logic       me = 1'b0;

    always @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            q.delete();
            mo = '0;
            me = 1'b0;
        end else begin
            if (!bus.push_bar && !bus.pop_bar) begin
                me = 1'b1;
            end else if (!bus.pop_bar) begin
                if (q.size() == 0) me = 1'b1;
                else mo = q.pop_back();
            end else begin
                if (!bus.push_bar) begin
                    if (q.size() == 4) me = 1'b1;
                    else q.push_back(mo);
                end
                if (!bus.load_bar)
                    mo = (mo & ~bus.mask) | (bus.in & bus.mask);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("cmp_out", 32'(bus.out), 32'(mo));
            chk("cmp_count", 32'(bus.count), 32'(q.size()));
            chk("cmp_empty", 32'(bus.empty), 32'(q.size() == 0));
            chk("cmp_full", 32'(bus.full), 32'(q.size() == 4));
            chk("cmp_err", 32'(bus.err), 32'(me));
        end
    end

    task automatic cyc(input logic lb, input logic pb, input logic ppb,
                       input logic [2:0] i, input logic [2:0] m);
        bus.load_bar = lb;
        bus.push_bar = pb;
        bus.pop_bar  = ppb;
        bus.in       = i;
        bus.mask     = m;
        @(negedge clk);
        bus.load_bar = 1'b1;
        bus.push_bar = 1'b1;
        bus.pop_bar  = 1'b1;
    endtask

    task automatic do_reset();
        #2 reset_bar = 1'b0;
        #1;
        @(negedge clk);
        reset_bar = 1'b1;
    endtask

    initial begin
        bus.in = '0;
        bus.mask = '0;
        bus.load_bar = 1'b1;
        bus.push_bar = 1'b1;
        bus.pop_bar = 1'b1;
        repeat (2) @(negedge clk);
        reset_bar = 1'b1;
        started = 1'b1;

        // reset without a clock edge
        cyc(0, 1, 1, 3'b111, 3'b111);
        chk("ld_111", 32'(bus.out), 32'h7);
        #2 reset_bar = 1'b0;
        #1;
        chk("async_out", 32'(bus.out), 32'h0);
        chk("async_cnt", 32'(bus.count), 32'h0);
        chk("async_empty", 32'(bus.empty), 32'h1);
        @(negedge clk);
        reset_bar = 1'b1;

        // load timing
        bus.in = 3'b101;
        bus.mask = 3'b111;
        bus.load_bar = 1'b0;
        #1 chk("pre_edge", 32'(bus.out), 32'h0);
        @(posedge clk);
        #1 chk("post_edge", 32'(bus.out), 32'h5);
        @(negedge clk);
        chk("at_negedge", 32'(bus.out), 32'h5);
        bus.load_bar = 1'b1;

        // mask
        cyc(0, 1, 1, 3'b010, 3'b011);
        chk("mask_ld", 32'(bus.out), 32'h6);
        repeat (3) @(negedge clk);
        chk("no_strobe", 32'(bus.out), 32'h6);

        // interrupt nesting
        cyc(0, 1, 1, 3'b101, 3'b111);
        cyc(0, 0, 1, 3'b000, 3'b111);
        chk("nest_out0", 32'(bus.out), 32'h0);
        chk("nest_cnt1", 32'(bus.count), 32'h1);
        cyc(0, 1, 1, 3'b011, 3'b111);
        cyc(1, 0, 1, 3'b000, 3'b000);
        chk("nest_cnt2", 32'(bus.count), 32'h2);
        cyc(1, 1, 0, 3'b000, 3'b000);
        chk("nest_pop1", 32'(bus.out), 32'h3);
        chk("nest_cnt3", 32'(bus.count), 32'h1);
        cyc(1, 1, 0, 3'b000, 3'b000);
        chk("nest_pop2", 32'(bus.out), 32'h5);
        chk("nest_empty", 32'(bus.empty), 32'h1);
        chk("nest_err", 32'(bus.err), 32'h0);

        // overflow
        cyc(0, 0, 1, 3'b010, 3'b111);
        cyc(0, 0, 1, 3'b011, 3'b111);
        cyc(0, 0, 1, 3'b100, 3'b111);
        cyc(0, 0, 1, 3'b110, 3'b111);
        chk("ovf_full", 32'(bus.full), 32'h1);
        chk("ovf_cnt", 32'(bus.count), 32'h4);
        cyc(0, 0, 1, 3'b001, 3'b111);
        chk("ovf5_cnt", 32'(bus.count), 32'h4);
        chk("ovf5_err", 32'(bus.err), 32'h1);
        chk("ovf5_out", 32'(bus.out), 32'h1);
        cyc(1, 1, 0, 3'b000, 3'b000);
        chk("lifo_0", 32'(bus.out), 32'h4);
        cyc(1, 1, 0, 3'b000, 3'b000);
        chk("lifo_1", 32'(bus.out), 32'h3);
        cyc(1, 1, 0, 3'b000, 3'b000);
        chk("lifo_2", 32'(bus.out), 32'h2);
        cyc(1, 1, 0, 3'b000, 3'b000);
        chk("lifo_3", 32'(bus.out), 32'h5);
        chk("lifo_err", 32'(bus.err), 32'h1);

        // underflow / conflict
        do_reset();
        cyc(1, 1, 0, 3'b000, 3'b000);
        chk("unf_out", 32'(bus.out), 32'h0);
        chk("unf_cnt", 32'(bus.count), 32'h0);
        chk("unf_err", 32'(bus.err), 32'h1);
        do_reset();
        cyc(0, 1, 1, 3'b110, 3'b111);
        cyc(1, 0, 1, 3'b000, 3'b000);
        cyc(1, 0, 0, 3'b000, 3'b000);
        chk("cfl_cnt", 32'(bus.count), 32'h1);
        chk("cfl_out", 32'(bus.out), 32'h6);
        chk("cfl_err", 32'(bus.err), 32'h1);
        cyc(0, 1, 0, 3'b111, 3'b111);
        chk("popld_out", 32'(bus.out), 32'h6);
        chk("popld_cnt", 32'(bus.count), 32'h0);

        // reset mid-operation
        do_reset();
        cyc(0, 0, 1, 3'b001, 3'b111);
        cyc(1, 0, 1, 3'b000, 3'b000);
        cyc(1, 0, 1, 3'b000, 3'b000);
        cyc(1, 0, 0, 3'b000, 3'b000);
        chk("mid_cnt", 32'(bus.count), 32'h3);
        chk("mid_err", 32'(bus.err), 32'h1);
        #2 reset_bar = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(bus.count), 32'h0);
        chk("mid_rst_err", 32'(bus.err), 32'h0);
        chk("mid_rst_out", 32'(bus.out), 32'h0);
        @(negedge clk);
        reset_bar = 1'b1;
        cyc(1, 1, 0, 3'b000, 3'b000);
        chk("rel_pop_err", 32'(bus.err), 32'h1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
